// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - shared subcycle codes, one-hot masks and period helper for the 4004 timing chain
//
// Purpose:
//   Common definitions for timing_gen and phase_gen.
//   - subcycle_e: 3-bit subcycle codes A1..X3 (0..7).
//   - CYC_*: one-hot subcycle masks (bit0 = A1 ... bit7 = X3).
//   - calc_period(): sysclk ticks per subcycle for a given phase/gap setting.
//   - cyc_mask(): one-hot mask for a subcycle code.
// Ports: none (package).

package timing_pkg;

  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  localparam logic [7:0] CYC_A1 = 8'h01;
  localparam logic [7:0] CYC_A2 = 8'h02;
  localparam logic [7:0] CYC_A3 = 8'h04;
  localparam logic [7:0] CYC_M1 = 8'h08;
  localparam logic [7:0] CYC_M2 = 8'h10;
  localparam logic [7:0] CYC_X1 = 8'h20;
  localparam logic [7:0] CYC_X2 = 8'h40;
  localparam logic [7:0] CYC_X3 = 8'h80;

  // Each subcycle is one clk1 phase, a gap, one clk2 phase and a second gap.
  function automatic int calc_period(input int tphi, input int tgap);
    return 2 * (tphi + tgap);
  endfunction

  function automatic logic [7:0] cyc_mask(input subcycle_e sc);
    logic [7:0] m;
    m = 8'h00;
    case (sc)
      SC_A1:   m = CYC_A1;
      SC_A2:   m = CYC_A2;
      SC_A3:   m = CYC_A3;
      SC_M1:   m = CYC_M1;
      SC_M2:   m = CYC_M2;
      SC_X1:   m = CYC_X1;
      SC_X2:   m = CYC_X2;
      SC_X3:   m = CYC_X3;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timing_gen_phase_gen.sv
// rtl/timing_gen_phase_gen.sv - subcycle tick counter with two-phase non-overlapping clock decode
//
// Purpose:
//   Counts sysclk ticks 0..P-1 inside one subcycle (P = 2*(TPHI+TGAP)) and
//   decodes the clk1/clk2 phase levels and their one-tick start strobes.
//   All outputs are registered from the count being loaded on the same edge,
//   so they line up with the counter with zero lag.
//
// Parameters:
//   TPHI  sysclk ticks each phase is high (>= 1)
//   TGAP  sysclk ticks of non-overlap after each phase (>= 1)
//
// Ports:
//   sysclk     in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   run        in   1 = advance the counter; 0 = hold and force outputs low
//   wrap       out  counter is at P-1 (next advancing edge wraps to 0)
//   clk1       out  phase-1 level
//   clk2       out  phase-2 level
//   clk1_step  out  one-tick strobe at the start of clk1 high
//   clk2_step  out  one-tick strobe at the start of clk2 high

module phase_gen
  import timing_pkg::*;
#(
  parameter int TPHI = 3,
  parameter int TGAP = 1
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic run,
  output logic wrap,
  output logic clk1,
  output logic clk2,
  output logic clk1_step,
  output logic clk2_step
);

  localparam int P  = calc_period(TPHI, TGAP);
  localparam int CW = $clog2(P);

  localparam logic [CW-1:0] CNT_MAX   = CW'(P - 1);
  localparam logic [CW-1:0] PH1_END   = CW'(TPHI - 1);
  localparam logic [CW-1:0] PH2_START = CW'(TPHI + TGAP);
  localparam logic [CW-1:0] PH2_END   = CW'(2 * TPHI + TGAP - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          clk1_d;
  logic          clk2_d;
  logic          clk1_step_d;
  logic          clk2_step_d;

  assign wrap = (cnt == CNT_MAX);

  always_comb begin
    cnt_nxt = cnt;
    if (run) begin
      cnt_nxt = wrap ? '0 : cnt + CW'(1);
    end
  end

  // Decode from cnt_nxt so the registered outputs track the new count.
  // When held, every phase output is forced low.
  always_comb begin
    clk1_d      = 1'b0;
    clk2_d      = 1'b0;
    clk1_step_d = 1'b0;
    clk2_step_d = 1'b0;
    if (run) begin
      clk1_d      = (cnt_nxt <= PH1_END);
      clk2_d      = (cnt_nxt >= PH2_START) && (cnt_nxt <= PH2_END);
      clk1_step_d = (cnt_nxt == '0);
      clk2_step_d = (cnt_nxt == PH2_START);
    end
  end

  // Reset parks the counter at P-1 so the first edge lands on tick 0.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= CNT_MAX;
      clk1      <= 1'b0;
      clk2      <= 1'b0;
      clk1_step <= 1'b0;
      clk2_step <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clk1      <= clk1_d;
      clk2      <= clk2_d;
      clk1_step <= clk1_step_d;
      clk2_step <= clk2_step_d;
    end
  end

endmodule

// File: rtl/timing_gen.sv
// rtl/timing_gen.sv - 4004 two-phase clock, subcycle sequencer and SYNC generator
//
// Purpose:
//   Top of the timing chain. Uses phase_gen for the tick counter and the
//   clk1/clk2 decode, and adds the A1..X3 subcycle register, the one-hot and
//   binary subcycle outputs and SYNC (high for the whole of X3).
//   Build option TIMING_GEN_SINGLE_STEP_EN adds step_req/halted: the block
//   parks after X3 until step_req is seen, then restarts at A1.
//
// Parameters:
//   TPHI  sysclk ticks each phase is high (>= 1)
//   TGAP  sysclk ticks of non-overlap after each phase (>= 1)
//
// Ports:
//   sysclk     in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   step_req   in   (TIMING_GEN_SINGLE_STEP_EN only) run/resume request
//   clk1       out  phase-1 level
//   clk2       out  phase-2 level, never overlapping clk1
//   clk1_step  out  one-tick strobe at each clk1 rise (step_a)
//   clk2_step  out  one-tick strobe at each clk2 rise (step_b)
//   cyc        out  one-hot subcycle, bit0 = A1 ... bit7 = X3
//   cyc_code   out  binary subcycle, A1 = 0 ... X3 = 7
//   sync       out  high throughout X3
//   halted     out  (TIMING_GEN_SINGLE_STEP_EN only) parked after X3

module timing_gen
  import timing_pkg::*;
#(
  parameter int TPHI = 3,
  parameter int TGAP = 1
) (
  input  logic       sysclk,
  input  logic       rst_n,
`ifdef TIMING_GEN_SINGLE_STEP_EN
  input  logic       step_req,
  output logic       halted,
`endif
  output logic       clk1,
  output logic       clk2,
  output logic       clk1_step,
  output logic       clk2_step,
  output logic [7:0] cyc,
  output logic [2:0] cyc_code,
  output logic       sync
);

  logic      run;
  logic      wrap;
  subcycle_e sub;
  subcycle_e sub_nxt;
  logic [7:0] cyc_d;
  logic [2:0] cyc_code_d;
  logic       sync_d;

  phase_gen #(
    .TPHI (TPHI),
    .TGAP (TGAP)
  ) u_phase_gen (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .run       (run),
    .wrap      (wrap),
    .clk1      (clk1),
    .clk2      (clk2),
    .clk1_step (clk1_step),
    .clk2_step (clk2_step)
  );

`ifdef TIMING_GEN_SINGLE_STEP_EN
  logic halted_q;
  logic halted_nxt;
  logic start_pend;
  logic halt_take;

  // start_pend marks the first edge after reset: the block sits at X3/P-1
  // there too, but that start must not be mistaken for a halt point.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q   <= 1'b0;
      start_pend <= 1'b1;
    end else begin
      halted_q   <= halted_nxt;
      start_pend <= 1'b0;
    end
  end

  // A halted block sits at X3/P-1, so releasing run on a step_req edge
  // wraps straight into A1 tick 0, exactly like the post-reset start.
  always_comb begin
    halt_take  = !start_pend && wrap && (sub == SC_X3) && !step_req;
    halted_nxt = !step_req && (halted_q || halt_take);
    run        = !halted_nxt;
  end

  assign halted = halted_q;
`else
  assign run = 1'b1;
`endif

  // Subcycle state register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sub <= SC_X3;
    end else begin
      sub <= sub_nxt;
    end
  end

  // Next subcycle: advance only when the tick counter wraps; X3 rolls to A1.
  always_comb begin
    sub_nxt = sub;
    if (run && wrap) begin
      sub_nxt = subcycle_e'(sub + 3'd1);
    end
  end

  // Output decode from the subcycle being loaded on this edge.
  always_comb begin
    cyc_d      = 8'h00;
    cyc_code_d = 3'd0;
    sync_d     = 1'b0;
    if (run) begin
      cyc_d      = cyc_mask(sub_nxt);
      cyc_code_d = sub_nxt;
      sync_d     = (sub_nxt == SC_X3);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 8'h00;
      cyc_code <= 3'd0;
      sync     <= 1'b0;
    end else begin
      cyc      <= cyc_d;
      cyc_code <= cyc_code_d;
      sync     <= sync_d;
    end
  end

endmodule

// File: tb/tb_timing_gen.sv
// tb/tb_timing_gen.sv - directed self-checking bench for timing_gen (P=8 and P=4 instances)

module tb_timing_gen;

  logic       sysclk = 1'b0;
  logic       rst_n;

  logic       clk1, clk2, clk1_step, clk2_step, sync;
  logic [7:0] cyc;
  logic [2:0] cyc_code;

  logic       b_clk1, b_clk2, b_clk1_step, b_clk2_step, b_sync;
  logic [7:0] b_cyc;
  logic [2:0] b_cyc_code;

`ifdef TIMING_GEN_SINGLE_STEP_EN
  logic step_req;
  logic halted;
  logic b_halted;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int t;
  int t2;
  int n1, n2, ns;

  logic cb_master, cb_q;

  always #5 sysclk = ~sysclk;

  timing_gen #(.TPHI(3), .TGAP(1)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
`ifdef TIMING_GEN_SINGLE_STEP_EN
    .step_req  (step_req),
    .halted    (halted),
`endif
    .clk1      (clk1),
    .clk2      (clk2),
    .clk1_step (clk1_step),
    .clk2_step (clk2_step),
    .cyc       (cyc),
    .cyc_code  (cyc_code),
    .sync      (sync)
  );

  timing_gen #(.TPHI(1), .TGAP(1)) dut_b (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
`ifdef TIMING_GEN_SINGLE_STEP_EN
    .step_req  (1'b1),
    .halted    (b_halted),
`endif
    .clk1      (b_clk1),
    .clk2      (b_clk2),
    .clk1_step (b_clk1_step),
    .clk2_step (b_clk2_step),
    .cyc       (b_cyc),
    .cyc_code  (b_cyc_code),
    .sync      (b_sync)
  );

  // Two-phase counter bit driven by the P=4 instance strobes.
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cb_master <= 1'b0;
      cb_q      <= 1'b0;
    end else begin
      if (b_clk1_step) cb_master <= ~cb_q;
      if (b_clk2_step) cb_q      <= cb_master;
    end
  end

  function automatic logic [7:0] b8(input logic b);
    return {7'b0, b};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d t2=%0d observed=%0h expected=%0h", tag, t, t2, obs, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_clk1"}, b8(clk1), 8'h00);
    check({tag, "_clk2"}, b8(clk2), 8'h00);
    check({tag, "_clk1_step"}, b8(clk1_step), 8'h00);
    check({tag, "_clk2_step"}, b8(clk2_step), 8'h00);
    check({tag, "_cyc"}, cyc, 8'h00);
    check({tag, "_cyc_code"}, {5'b0, cyc_code}, 8'h00);
    check({tag, "_sync"}, b8(sync), 8'h00);
  endtask

  // P=8: clk1 ticks 0..2, clk2 ticks 4..6, machine cycle 64 ticks.
  task automatic check_main();
    int cnt;
    int sub;
    cnt = t % 8;
    sub = (t / 8) % 8;
    check("clk1", b8(clk1), b8(cnt < 3));
    check("clk2", b8(clk2), b8(cnt >= 4 && cnt <= 6));
    check("clk1_step", b8(clk1_step), b8(cnt == 0));
    check("clk2_step", b8(clk2_step), b8(cnt == 4));
    check("cyc", cyc, 8'(32'd1 << sub));
    check("cyc_code", {5'b0, cyc_code}, 8'(sub));
    check("sync", b8(sync), b8(sub == 7));
    check("overlap", b8(clk1 & clk2), 8'h00);
`ifdef TIMING_GEN_SINGLE_STEP_EN
    check("halted", b8(halted), 8'h00);
`endif
    n1 += int'(clk1_step);
    n2 += int'(clk2_step);
    ns += int'(sync);
    if (cnt == 7 && sub == 7) begin
      check("n_clk1_step", 8'(n1), 8'd8);
      check("n_clk2_step", 8'(n2), 8'd8);
      check("n_sync", 8'(ns), 8'd8);
      n1 = 0;
      n2 = 0;
      ns = 0;
    end
  endtask

  // P=4: clk1 at tick 0, clk2 at tick 2; counter bit toggles once per subcycle.
  task automatic check_b();
    int cnt;
    int sub;
    cnt = t2 % 4;
    sub = (t2 / 4) % 8;
    check("b_clk1", b8(b_clk1), b8(cnt == 0));
    check("b_clk2", b8(b_clk2), b8(cnt == 2));
    check("b_clk1_step", b8(b_clk1_step), b8(cnt == 0));
    check("b_clk2_step", b8(b_clk2_step), b8(cnt == 2));
    check("b_overlap", b8(b_clk1 & b_clk2), 8'h00);
    check("b_cyc_code", {5'b0, b_cyc_code}, 8'(sub));
    check("b_sync", b8(b_sync), b8(sub == 7));
    if (cnt == 0) check("cbit_q", b8(cb_q), b8(((t2 / 4) % 2) == 1));
  endtask

  task automatic tick(input bit chk_main);
    @(posedge sysclk);
    #1;
    t++;
    t2++;
    if (chk_main) check_main();
    check_b();
  endtask

  task automatic restart_counters();
    t  = -1;
    t2 = -1;
    n1 = 0;
    n2 = 0;
    ns = 0;
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef TIMING_GEN_SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    restart_counters();

    // Reset state.
    #23;
    check_all_low("rst");
    check("rst_b_clk1", b8(b_clk1), 8'h00);
    check("rst_b_cyc", b_cyc, 8'h00);
`ifdef TIMING_GEN_SINGLE_STEP_EN
    check("rst_halted", b8(halted), 8'h00);
`endif

    // Release and run three machine cycles (step_req held high when present).
    #4;
    rst_n = 1'b1;
    tick(1'b1);
    check("first_cyc", cyc, 8'h01);
    check("first_clk1_step", b8(clk1_step), 8'h01);
    repeat (191) tick(1'b1);

    // Into the fourth cycle up to X1 tick 5, then asynchronous reset.
    repeat (46) tick(1'b1);
    check("pre_rst_cyc", cyc, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("async_rst");
    check("async_rst_b_clk1_step", b8(b_clk1_step), 8'h00);

    #22;
`ifdef TIMING_GEN_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    restart_counters();
    rst_n = 1'b1;
    tick(1'b1);
    check("restart_cyc", cyc, 8'h01);
    check("restart_clk1", b8(clk1), 8'h01);
    repeat (63) tick(1'b1);

`ifdef TIMING_GEN_SINGLE_STEP_EN
    // Wrap out of X3 with step_req low parks the block.
    repeat (20) begin
      tick(1'b0);
      check("halt_halted", b8(halted), 8'h01);
      check_all_low("halt");
    end
    step_req = 1'b1;
    t = -1;
    tick(1'b1);
    check("resume_cyc", cyc, 8'h01);
    check("resume_clk1_step", b8(clk1_step), 8'h01);
    check("resume_halted", b8(halted), 8'h00);
    step_req = 1'b0;
    repeat (63) tick(1'b1);
    tick(1'b0);
    check("rehalt_halted", b8(halted), 8'h01);
    check_all_low("rehalt");
`else
    repeat (64) tick(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
